bus_source_arbiter: RTL and testbench
=====================================

Name: bus_source_arbiter

Overview:
- Parametrised successor to the processor datapath's two-source bus mux.
- Drives the shared datapath bus from N_SRC register/ALU sources plus one external-input path.
- Sources are selected by round-robin arbitration, and each grant can be held for a bounded number of cycles.
- The bus value is registered, and the bus drives zero when no source is granted.

Parameters:
- N_SRC, 4, number of internal bus sources (2..8).
- WIDTH, 4, bus data width in bits.
- MAX_HOLD, 3, maximum consecutive cycles one source may hold the grant while others request (1..15).

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- req  input  N_SRC  per-source bus request; bit i belongs to source i.
- src_data  input  N_SRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- ext_req  input  1  external-input override request.
- ext_data  input  WIDTH  external input data.
- grant  output  N_SRC  registered one-hot grant, or all zeros.
- ext_grant  output  1  registered; external path owns the bus.
- bus_out  output  WIDTH  registered bus value.
- bus_valid  output  1  registered; bus_out carries granted data.
- hold_cnt  output  clog2(MAX_HOLD+1)  cycles the current internal grant has been held, minus 1.

Behaviour:
- Reset (async, immediate):
  - grant=0, ext_grant=0, bus_out=0, bus_valid=0, hold_cnt=0.
  - RR pointer = 0, meaning source 0 has highest priority first. State = IDLE.
- States:
  - IDLE: no owner.
  - INT: internal source owns the bus.
  - EXT: external path owns the bus.
- Next owner is decided combinationally from the current inputs and state. All outputs update at the next rising edge, so latency from request to grant/bus is 1 cycle.
- ext_req has absolute priority from any state:
  - ext_req=1 → EXT next cycle, ext_grant=1, grant=0, bus_out=ext_data, hold_cnt=0.
  - An internal grant is preempted immediately. The RR pointer is not changed by preemption.
- EXT with ext_req=0: internal arbitration proceeds as from IDLE.
- IDLE, or leaving EXT:
  - If any req is set, grant the first requester at or after the RR pointer, wrapping mod N_SRC. Enter INT with hold_cnt=0.
  - Otherwise stay in IDLE.
- INT with owner g:
  - req[g]=0 → release. Pick a new requester (may be none → IDLE); the RR pointer becomes g+1 mod N_SRC.
  - req[g]=1 and hold_cnt < MAX_HOLD-1 → keep g, hold_cnt+1.
  - req[g]=1 and hold_cnt = MAX_HOLD-1:
    - If another source requests, rotate: RR pointer = g+1, grant the next requester, hold_cnt=0.
    - If no other source requests, re-grant g with hold_cnt=0. There is no idle bubble.
- bus_out each edge:
  - src_data slice of the next owner, or ext_data in EXT.
  - 0 with bus_valid=0 in IDLE.
  - While a grant is held, bus_out tracks the owner's src_data with 1-cycle latency.
- Width rules:
  - hold_cnt saturates logic is not needed; the counter never exceeds MAX_HOLD-1.
  - The RR pointer is clog2(N_SRC) bits and wraps explicitly mod N_SRC, including for non-power-of-2 N_SRC.
- Invariants:
  - grant is one-hot or zero.
  - grant and ext_grant are never both nonzero.
  - bus_valid = |grant | ext_grant.
- Simultaneous events: owner drop and new requests in the same cycle → the new owner is granted the next cycle; no dead cycle.
- Reset mid-grant: all outputs clear asynchronously. After deassertion the first grant starts from source 0 priority.

Decomposition:
- Shared package bus_arb_pkg:
  - State encoding: IDLE=2'd0, INT=2'd1, EXT=2'd2.
  - Localparam helper for pointer width (clog2).
- Sub-module rr_pick:
  - Combinational rotate-priority encoder.
  - Inputs: req vector and pointer.
  - Outputs: one-hot pick and any_req.
  - Instantiated once.
- State, pointer, counter and bus register stay in the top module.

Test Plan (N_SRC=4, WIDTH=4, MAX_HOLD=3):
- Reset: assert Reset mid-grant with req=4'b0010 → all outputs 0 immediately. Release with req=4'b1111 → next edge grant=4'b0001, bus_out=src_data[0].
- Hold limit and fairness:
  - Stimulus: req=4'b0011 constant, src0=4'hA, src1=4'h5.
  - Required grant sequence: 0001,0001,0001,0010,0010,0010,0001.
  - Required hold_cnt sequence: 0,1,2,0,1,2,0.
  - bus_out alternates A/5 accordingly.
- Lone requester: req=4'b0100 for 8 cycles → grant=4'b0100 every cycle, hold_cnt cycles 0,1,2,0,…, bus_valid never drops.
- External preemption:
  - Stimulus: src2 granted; ext_req=1 with ext_data=4'hF for 2 cycles.
  - Required: next edge ext_grant=1, grant=0, bus_out=F.
  - After ext_req drops: src2 regranted with hold_cnt=0.
- Release and wrap:
  - Stimulus: owner 3 drops req while req=4'b1001 → ... pointer wraps to 0, grant=4'b0001 next edge.
  - Stimulus: all req drop → IDLE, bus_out=0, bus_valid=0.
- Data tracking: src1 owner, src_data[1] changes 3→7 mid-grant → bus_out shows 7 exactly one cycle later, grant unchanged.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus source arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    // Bus ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        EXT  = 2'd2
    } arb_state_t;

    // Width of a source index / round-robin pointer; never below 1 bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_source_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the arbiter state logic.
//
// Ports:
//   req      - request vector, bit i belongs to source i
//   ptr      - index of the highest-priority source (must be < N)
//   pick     - one-hot winner, or zero when nothing requests
//   pick_idx - binary index of the winner (0 when nothing requests)
//   any_req  - at least one request is set
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] pick_idx,
    output logic          any_req
);

    always_comb begin
        int   j;
        logic found;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap so non-power-of-2 N is handled correctly.
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j[PW-1:0]]) begin
                found             = 1'b1;
                pick[j[PW-1:0]]   = 1'b1;
                pick_idx          = j[PW-1:0];
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin bus arbiter: N_SRC internal sources plus an overriding external path.
// Latency: 1 cycle from request/data to registered grant and bus value.
// Backpressure: none; external request preempts, grants are held at most MAX_HOLD cycles under contention.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-high reset
//   req, src_data     - per-source request and packed data (source i at [i*WIDTH +: WIDTH])
//   ext_req, ext_data - external override request and data
//   grant, ext_grant  - registered one-hot internal grant / external grant
//   bus_out, bus_valid- registered bus value, zero and invalid when idle
//   hold_cnt          - cycles the current internal grant has been held, minus 1
module bus_source_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              req,
    input  logic [N_SRC*WIDTH-1:0]        src_data,
    input  logic                          ext_req,
    input  logic [WIDTH-1:0]              ext_data,
    output logic [N_SRC-1:0]              grant,
    output logic                          ext_grant,
    output logic [WIDTH-1:0]              bus_out,
    output logic                          bus_valid,
    output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt
);

    localparam int PW = ptr_width(N_SRC);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t     state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  own_q, own_d;
    logic [HW-1:0]  hold_d;
    logic [N_SRC-1:0] grant_d;
    logic           ext_grant_d;
    logic [WIDTH-1:0] bus_d;
    logic           bus_valid_d;

    logic [PW-1:0]  own_step;
    logic [N_SRC-1:0] pick_vec;
    logic [PW-1:0]  pick_ptr;
    logic [N_SRC-1:0] pick;
    logic [PW-1:0]  pick_idx;
    logic           pick_any;

    assign own_step = (own_q == PW'(N_SRC - 1)) ? '0 : own_q + 1'b1;

    // While a source owns the bus, the encoder searches the other sources
    // starting just after the owner. That serves both release (owner's req
    // is already low) and hold-limit rotation (owner must not win again).
    // grant is one-hot on the owner in INT, so it doubles as the mask.
    assign pick_vec = (state_q == INT) ? (req & ~grant) : req;
    assign pick_ptr = (state_q == INT) ? own_step : ptr_q;

    rr_pick #(
        .N  (N_SRC),
        .PW (PW)
    ) u_rr_pick (
        .req      (pick_vec),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any_req  (pick_any)
    );

    always_comb begin
        logic keep;
        logic take_pick;
        state_d     = state_q;
        ptr_d       = ptr_q;
        own_d       = own_q;
        hold_d      = '0;
        grant_d     = '0;
        ext_grant_d = 1'b0;
        bus_d       = '0;
        bus_valid_d = 1'b0;
        keep        = 1'b0;
        take_pick   = 1'b0;

        if (ext_req) begin
            // Preemption leaves the pointer alone.
            state_d     = EXT;
            ext_grant_d = 1'b1;
            bus_d       = ext_data;
            bus_valid_d = 1'b1;
        end else if (state_q == INT && req[own_q]) begin
            if (int'(hold_cnt) < MAX_HOLD - 1) begin
                keep   = 1'b1;
                hold_d = hold_cnt + 1'b1;
            end else if (pick_any) begin
                ptr_d     = own_step;
                take_pick = 1'b1;
            end else begin
                // Nobody else wants the bus: restart the hold window, no bubble.
                keep = 1'b1;
            end
        end else if (state_q == INT) begin
            ptr_d     = own_step;
            take_pick = 1'b1;
        end else begin
            take_pick = 1'b1;
        end

        if (keep) begin
            state_d     = INT;
            grant_d     = grant;
            bus_d       = src_data[int'(own_q)*WIDTH +: WIDTH];
            bus_valid_d = 1'b1;
        end else if (take_pick) begin
            if (pick_any) begin
                state_d     = INT;
                own_d       = pick_idx;
                grant_d     = pick;
                bus_d       = src_data[int'(pick_idx)*WIDTH +: WIDTH];
                bus_valid_d = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            ext_grant <= 1'b0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            own_q     <= own_d;
            hold_cnt  <= hold_d;
            grant     <= grant_d;
            ext_grant <= ext_grant_d;
            bus_out   <= bus_d;
            bus_valid <= bus_valid_d;
        end
    end

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter (N_SRC=4, WIDTH=4, MAX_HOLD=3).
// Latency: expects outputs one clock after inputs.
// Backpressure: n/a.
module tb_bus_source_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MH = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] src_data = '0;
    logic         ext_req = 1'b0;
    logic [W-1:0] ext_data = '0;
    logic [N-1:0] grant;
    logic         ext_grant;
    logic [W-1:0] bus_out;
    logic         bus_valid;
    logic [1:0]   hold_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner index, -1 = nobody, -2 = external path.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    logic [N-1:0] m_grant = '0;
    logic         m_ext   = 1'b0;
    logic [W-1:0] m_bus   = '0;
    logic         m_valid = 1'b0;

    bus_source_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .ext_req   (ext_req),
        .ext_data  (ext_data),
        .grant     (grant),
        .ext_grant (ext_grant),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .hold_cnt  (hold_cnt)
    );

    always #5 clk = ~clk;

    function automatic int first_req(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0;
        m_grant = '0; m_ext = 1'b0; m_bus = '0; m_valid = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, then the DUT.
    task automatic tick();
        if (ext_req) begin
            m_owner = -2;
            m_hold  = 0;
        end else if (m_owner >= 0 && req[m_owner] && m_hold < MH - 1) begin
            m_hold = m_hold + 1;
        end else if (m_owner >= 0 && req[m_owner]) begin
            if ((req & ~(4'b0001 << m_owner)) != 0) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = first_req(req, m_ptr);
            end
            m_hold = 0;
        end else if (m_owner >= 0) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = first_req(req, m_ptr);
            m_hold  = 0;
        end else begin
            m_owner = first_req(req, m_ptr);
            m_hold  = 0;
        end
        m_ext   = (m_owner == -2);
        m_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        m_valid = (m_owner != -1);
        if (m_owner == -2)     m_bus = ext_data;
        else if (m_owner >= 0) m_bus = src_data[m_owner*W +: W];
        else                   m_bus = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; req = '0; ext_req = 1'b0;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({grant, ext_grant, bus_out, bus_valid, hold_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_initial: got g=%b e=%b b=%h v=%b h=%0d want all 0", grant, ext_grant, bus_out, bus_valid, hold_cnt);
        end
        reset_dut();
        req = 4'b0010; src_data = 16'h4321;
        tick(); tick();
        checks++;
        if (grant !== 4'b0010 || bus_out !== 4'h2) begin
            failures++;
            $display("FAIL reset_pregrant: got g=%b b=%h want g=0010 b=2", grant, bus_out);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({grant, ext_grant, bus_out, bus_valid, hold_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_async: got g=%b e=%b b=%h v=%b h=%0d want all 0", grant, ext_grant, bus_out, bus_valid, hold_cnt);
        end
        req = 4'b1111;
        #1 rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || bus_out !== 4'h1 || bus_valid !== 1'b1 || hold_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_grant: got g=%b b=%h v=%b h=%0d want g=0001 b=1 v=1 h=0", grant, bus_out, bus_valid, hold_cnt);
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp_g [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        int         exp_h [7] = '{0, 1, 2, 0, 1, 2, 0};
        logic [3:0] exp_b;
        reset_dut();
        req = 4'b0011; src_data = 16'h005A;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_b = (exp_g[i] == 4'b0001) ? 4'hA : 4'h5;
            checks++;
            if (grant !== exp_g[i] || int'(hold_cnt) != exp_h[i] || bus_out !== exp_b) begin
                failures++;
                $display("FAIL hold_limit[%0d]: got g=%b h=%0d b=%h want g=%b h=%0d b=%h", i, grant, hold_cnt, bus_out, exp_g[i], exp_h[i], exp_b);
            end
        end
    endtask

    task automatic test_lone_requester();
        reset_dut();
        req = 4'b0100; src_data = 16'h0C00;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0100 || int'(hold_cnt) != i % 3 || bus_valid !== 1'b1 || bus_out !== 4'hC) begin
                failures++;
                $display("FAIL lone[%0d]: got g=%b h=%0d v=%b b=%h want g=0100 h=%0d v=1 b=c", i, grant, hold_cnt, bus_valid, bus_out, i % 3);
            end
        end
    endtask

    task automatic test_ext_preempt();
        reset_dut();
        req = 4'b0100; src_data = 16'h0300;
        tick();
        ext_req = 1'b1; ext_data = 4'hF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ext_grant !== 1'b1 || grant !== 4'b0000 || bus_out !== 4'hF || bus_valid !== 1'b1 || hold_cnt !== 2'd0) begin
                failures++;
                $display("FAIL ext_preempt[%0d]: got e=%b g=%b b=%h v=%b h=%0d want e=1 g=0000 b=f v=1 h=0", i, ext_grant, grant, bus_out, bus_valid, hold_cnt);
            end
        end
        ext_req = 1'b0;
        tick();
        checks++;
        if (ext_grant !== 1'b0 || grant !== 4'b0100 || hold_cnt !== 2'd0 || bus_out !== 4'h3) begin
            failures++;
            $display("FAIL ext_release: got e=%b g=%b h=%0d b=%h want e=0 g=0100 h=0 b=3", ext_grant, grant, hold_cnt, bus_out);
        end
    endtask

    task automatic test_release_wrap();
        reset_dut();
        req = 4'b1000; src_data = 16'h8009;
        tick();
        req = 4'b1001;
        tick();
        checks++;
        if (grant !== 4'b1000 || hold_cnt !== 2'd1) begin
            failures++;
            $display("FAIL wrap_hold: got g=%b h=%0d want g=1000 h=1", grant, hold_cnt);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || hold_cnt !== 2'd0 || bus_out !== 4'h9) begin
            failures++;
            $display("FAIL wrap_grant: got g=%b h=%0d b=%h want g=0001 h=0 b=9", grant, hold_cnt, bus_out);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || ext_grant !== 1'b0 || bus_out !== 4'h0 || bus_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle: got g=%b e=%b b=%h v=%b want all 0", grant, ext_grant, bus_out, bus_valid);
        end
    endtask

    task automatic test_data_tracking();
        reset_dut();
        req = 4'b0010; src_data = 16'h0030;
        tick();
        src_data = 16'h0070;
        #3;
        checks++;
        if (bus_out !== 4'h3 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL track_before: got b=%h g=%b want b=3 g=0010", bus_out, grant);
        end
        tick();
        checks++;
        if (bus_out !== 4'h7 || grant !== 4'b0010) begin
            failures++;
            $display("FAIL track_after: got b=%h g=%b want b=7 g=0010", bus_out, grant);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            req      = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 1) << $urandom_range(0, 3));
            ext_req  = ($urandom_range(0, 9) == 0);
            ext_data = 4'($urandom);
            src_data = 16'($urandom);
            tick();
            checks++;
            if (grant !== m_grant || ext_grant !== m_ext || bus_out !== m_bus || bus_valid !== m_valid || int'(hold_cnt) != m_hold) begin
                failures++;
                $display("FAIL random[%0d]: got g=%b e=%b b=%h v=%b h=%0d want g=%b e=%b b=%h v=%b h=%0d", i, grant, ext_grant, bus_out, bus_valid, hold_cnt, m_grant, m_ext, m_bus, m_valid, m_hold);
            end
            checks++;
            if ($countones(grant) > 1 || (grant != 0 && ext_grant) || bus_valid !== (|grant | ext_grant)) begin
                failures++;
                $display("FAIL invariant[%0d]: got g=%b e=%b v=%b want onehot0 exclusive consistent", i, grant, ext_grant, bus_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_limit();
        test_lone_requester();
        test_ext_preempt();
        test_release_wrap();
        test_data_tracking();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
